// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh
// Power-up initialisation and periodic auto-refresh sequencer for the SDRAM
// controller (sdram_clk domain). After reset it holds CKE low for the powerup
// wait, then runs PRECHARGE ALL, two AUTO REFRESH and LOAD MODE REGISTER.
// Afterwards a free-running interval timer accumulates pending refreshes,
// which are issued as PRECHARGE ALL + AUTO REFRESH once the access state
// machine grants the bus. All outputs come straight from registers.
module sdram_init_refresh #(
    parameter int CLK_FREQ_MHZ  = 100,
    parameter int POWERUP_DELAY = 200,
    parameter int REFRESH_MS    = 64,
    parameter int REFRESH_ROWS  = 8192,
    parameter int BURST_LENGTH  = 8,
    parameter int tCAC          = 2,
    parameter int tRP           = 2,
    parameter int tRC           = 7,
    parameter int tMRD          = 2
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    output logic        cke_o,
    output logic [3:0]  cmd_o,
    output logic [12:0] a_o,
    output logic [1:0]  ba_o,
    output logic        init_done_o,
    output logic        ref_req_o,
    input  logic        ref_gnt_i,
    output logic        busy_o
);

    // Derived timing
    localparam int PWRUP_CYCLES = POWERUP_DELAY * CLK_FREQ_MHZ;
    localparam int REF_INTERVAL = (REFRESH_MS * 1000 * CLK_FREQ_MHZ) / REFRESH_ROWS;
    localparam int PWR_W        = $clog2(PWRUP_CYCLES + 1);

    // Command encodings {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    // FSM states
    localparam logic [2:0] S_PWRUP     = 3'd0;
    localparam logic [2:0] S_INIT_PRE  = 3'd1;
    localparam logic [2:0] S_INIT_REF1 = 3'd2;
    localparam logic [2:0] S_INIT_REF2 = 3'd3;
    localparam logic [2:0] S_INIT_LMR  = 3'd4;
    localparam logic [2:0] S_IDLE      = 3'd5;
    localparam logic [2:0] S_RF_PRE    = 3'd6;
    localparam logic [2:0] S_RF_REF    = 3'd7;

    // Wait-counter reload values: a command at cycle N frees the bus at N+t,
    // so the counter holds t-1 NOP cycles.
    localparam logic [7:0] T_RP_M1  = 8'(tRP - 1);
    localparam logic [7:0] T_RC_M1  = 8'(tRC - 1);
    localparam logic [7:0] T_MRD_M1 = 8'(tMRD - 1);

    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYCLES);
    localparam logic [15:0]      TMR_LAST = 16'(REF_INTERVAL - 1);

    // A10 high selects "all banks" for PRECHARGE
    localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

    // Mode register burst-length field; unsupported lengths fall back to 8
    function automatic logic [2:0] bl_code(input logic [31:0] bl);
        logic [2:0] code;
        case (bl)
            32'd0:   code = 3'd7;
            32'd1:   code = 3'd0;
            32'd2:   code = 3'd1;
            32'd4:   code = 3'd2;
            32'd8:   code = 3'd3;
            default: code = 3'd3;
        endcase
        return code;
    endfunction

    // Mode register word: reserved zeros, CAS latency, sequential burst, BL
    localparam logic [12:0] MODE_WORD = {6'd0, 3'(tCAC), 1'b0, bl_code(32'(BURST_LENGTH))};

    // Registers
    logic [2:0]       state_r;
    logic [PWR_W-1:0] pwr_cnt_r;
    logic [7:0]       wait_r;
    logic             pre_sent_r;
    logic [15:0]      timer_r;
    logic [2:0]       pending_r;
    logic             cke_r;
    logic [3:0]       cmd_r;
    logic [12:0]      a_r;
    logic             init_done_r;
    logic             ref_req_r;
    logic             busy_r;

    // Next-state values
    logic [2:0]       state_s;
    logic [PWR_W-1:0] pwr_cnt_s;
    logic [7:0]       wait_s;
    logic             pre_sent_s;
    logic [15:0]      timer_s;
    logic [2:0]       pending_s;
    logic             cke_s;
    logic [3:0]       cmd_s;
    logic [12:0]      a_s;
    logic             init_done_s;
    logic             ref_req_s;
    logic             busy_s;
    logic             tick_s;
    logic             ref_dec_s;

    // Sequencer: command, address and ownership for the next cycle
    always_comb begin
        state_s     = state_r;
        pwr_cnt_s   = pwr_cnt_r;
        wait_s      = wait_r;
        pre_sent_s  = pre_sent_r;
        cke_s       = cke_r;
        cmd_s       = CMD_NOP;
        a_s         = 13'h0000;
        init_done_s = init_done_r;
        busy_s      = busy_r;
        ref_dec_s   = 1'b0;
        case (state_r)
            S_PWRUP: begin
                if (pwr_cnt_r == PWR_LAST) begin
                    cke_s   = 1'b1;
                    cmd_s   = CMD_PRE;
                    a_s     = ADDR_PRE_ALL;
                    wait_s  = T_RP_M1;
                    state_s = S_INIT_PRE;
                end else begin
                    cke_s     = 1'b0;
                    cmd_s     = CMD_INHIBIT;
                    pwr_cnt_s = pwr_cnt_r + PWR_W'(1'b1);
                end
            end
            S_INIT_PRE: begin
                if (wait_r == 8'd0) begin
                    cmd_s   = CMD_REF;
                    wait_s  = T_RC_M1;
                    state_s = S_INIT_REF1;
                end else begin
                    wait_s = wait_r - 8'd1;
                end
            end
            S_INIT_REF1: begin
                if (wait_r == 8'd0) begin
                    cmd_s   = CMD_REF;
                    wait_s  = T_RC_M1;
                    state_s = S_INIT_REF2;
                end else begin
                    wait_s = wait_r - 8'd1;
                end
            end
            S_INIT_REF2: begin
                if (wait_r == 8'd0) begin
                    cmd_s   = CMD_LMR;
                    a_s     = MODE_WORD;
                    wait_s  = T_MRD_M1;
                    state_s = S_INIT_LMR;
                end else begin
                    wait_s = wait_r - 8'd1;
                end
            end
            S_INIT_LMR: begin
                if (wait_r == 8'd0) begin
                    init_done_s = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = S_IDLE;
                end else begin
                    wait_s = wait_r - 8'd1;
                end
            end
            S_IDLE: begin
                // Grant only counts while a refresh is actually requested
                if (ref_gnt_i && ref_req_r) begin
                    pre_sent_s = 1'b0;
                    state_s    = S_RF_PRE;
                end else begin
                    pre_sent_s = pre_sent_r;
                end
            end
            S_RF_PRE: begin
                if (!pre_sent_r) begin
                    busy_s     = 1'b1;
                    cmd_s      = CMD_PRE;
                    a_s        = ADDR_PRE_ALL;
                    pre_sent_s = 1'b1;
                    wait_s     = T_RP_M1;
                end else if (wait_r == 8'd0) begin
                    cmd_s     = CMD_REF;
                    wait_s    = T_RC_M1;
                    ref_dec_s = 1'b1;
                    state_s   = S_RF_REF;
                end else begin
                    wait_s = wait_r - 8'd1;
                end
            end
            S_RF_REF: begin
                if (wait_r == 8'd0) begin
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    wait_s = wait_r - 8'd1;
                end
            end
            default: begin
                state_s     = S_PWRUP;
                pwr_cnt_s   = {PWR_W{1'b0}};
                wait_s      = 8'd0;
                cke_s       = 1'b0;
                cmd_s       = CMD_INHIBIT;
                init_done_s = 1'b0;
                busy_s      = 1'b1;
            end
        endcase
    end

    // Refresh interval timer and saturating pending-refresh count
    always_comb begin
        timer_s   = 16'd0;
        tick_s    = 1'b0;
        pending_s = pending_r;
        if (!init_done_r) begin
            timer_s = 16'd0;
        end else if (timer_r == TMR_LAST) begin
            timer_s = 16'd0;
            tick_s  = 1'b1;
        end else begin
            timer_s = timer_r + 16'd1;
        end
        case ({tick_s, ref_dec_s})
            2'b10: begin
                // At 7 the extra refresh is dropped
                if (pending_r != 3'd7) begin
                    pending_s = pending_r + 3'd1;
                end else begin
                    pending_s = pending_r;
                end
            end
            2'b01: begin
                if (pending_r != 3'd0) begin
                    pending_s = pending_r - 3'd1;
                end else begin
                    pending_s = pending_r;
                end
            end
            2'b11:   pending_s = pending_r;
            2'b00:   pending_s = pending_r;
            default: pending_s = pending_r;
        endcase
        ref_req_s = (pending_r != 3'd0);
    end

    // State and output registers, asynchronous reset to powerup
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_r     <= S_PWRUP;
            pwr_cnt_r   <= {PWR_W{1'b0}};
            wait_r      <= 8'd0;
            pre_sent_r  <= 1'b0;
            timer_r     <= 16'd0;
            pending_r   <= 3'd0;
            cke_r       <= 1'b0;
            cmd_r       <= CMD_INHIBIT;
            a_r         <= 13'h0000;
            init_done_r <= 1'b0;
            ref_req_r   <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            pwr_cnt_r   <= pwr_cnt_s;
            wait_r      <= wait_s;
            pre_sent_r  <= pre_sent_s;
            timer_r     <= timer_s;
            pending_r   <= pending_s;
            cke_r       <= cke_s;
            cmd_r       <= cmd_s;
            a_r         <= a_s;
            init_done_r <= init_done_s;
            ref_req_r   <= ref_req_s;
            busy_r      <= busy_s;
        end
    end

    assign cke_o       = cke_r;
    assign cmd_o       = cmd_r;
    assign a_o         = a_r;
    assign ba_o        = 2'b00;
    assign init_done_o = init_done_r;
    assign ref_req_o   = ref_req_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed testbench for sdram_init_refresh: init cycle map, mode register
// encodings, refresh handshake, tick/decrement collision, backlog saturation
// and asynchronous reset in the middle of init and refresh.
module tb_sdram_init_refresh;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gnt = 1'b0;
    logic gnt_off = 1'b0;

    logic        m_cke, m_done, m_req, m_busy;
    logic [3:0]  m_cmd;
    logic [12:0] m_a;
    logic [1:0]  m_ba;
    logic        b0_cke, b0_done, b0_req, b0_busy;
    logic [3:0]  b0_cmd;
    logic [12:0] b0_a;
    logic [1:0]  b0_ba;
    logic        b1_cke, b1_done, b1_req, b1_busy;
    logic [3:0]  b1_cmd;
    logic [12:0] b1_a;
    logic [1:0]  b1_ba;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    always #5 clk = ~clk;

    sdram_init_refresh #(.CLK_FREQ_MHZ(10), .POWERUP_DELAY(1), .REFRESH_MS(1), .REFRESH_ROWS(100)) dut (
        .sdram_clk(clk), .sdram_rst(rst), .cke_o(m_cke), .cmd_o(m_cmd), .a_o(m_a), .ba_o(m_ba),
        .init_done_o(m_done), .ref_req_o(m_req), .ref_gnt_i(gnt), .busy_o(m_busy));

    sdram_init_refresh #(.CLK_FREQ_MHZ(10), .POWERUP_DELAY(1), .BURST_LENGTH(0), .tCAC(3)) dut_bl0 (
        .sdram_clk(clk), .sdram_rst(rst), .cke_o(b0_cke), .cmd_o(b0_cmd), .a_o(b0_a), .ba_o(b0_ba),
        .init_done_o(b0_done), .ref_req_o(b0_req), .ref_gnt_i(gnt_off), .busy_o(b0_busy));

    sdram_init_refresh #(.CLK_FREQ_MHZ(10), .POWERUP_DELAY(1), .BURST_LENGTH(1)) dut_bl1 (
        .sdram_clk(clk), .sdram_rst(rst), .cke_o(b1_cke), .cmd_o(b1_cmd), .a_o(b1_a), .ba_o(b1_ba),
        .init_done_o(b1_done), .ref_req_o(b1_req), .ref_gnt_i(gnt_off), .busy_o(b1_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) tick1();
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_cke"},  32'(m_cke),  32'd0);
        chk({tag, "_cmd"},  32'(m_cmd),  32'hF);
        chk({tag, "_a"},    32'(m_a),    32'd0);
        chk({tag, "_ba"},   32'(m_ba),   32'd0);
        chk({tag, "_done"}, 32'(m_done), 32'd0);
        chk({tag, "_req"},  32'(m_req),  32'd0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd1);
    endtask

    // Release reset between edges; the next edge is cycle 0
    task automatic release_rst();
        tick1();
        tick1();
        rst = 1'b0;
        cyc = -1;
    endtask

    // Hand-derived init map for W=10, tRP=2, tRC=7, tMRD=2
    function automatic logic [3:0] exp_cmd(input int c);
        if (c < 10)       return 4'hF;
        else if (c == 10) return 4'h2;
        else if (c == 12) return 4'h1;
        else if (c == 19) return 4'h1;
        else if (c == 26) return 4'h0;
        else              return 4'h7;
    endfunction

    function automatic logic [12:0] exp_a(input int c);
        if (c == 10)      return 13'h0400;
        else if (c == 26) return 13'h0023;
        else              return 13'h0000;
    endfunction

    task automatic init_map(input string tag);
        for (int c = 0; c <= 28; c++) begin
            tick1();
            chk({tag, "_cmd"},  32'(m_cmd),  32'(exp_cmd(c)));
            chk({tag, "_a"},    32'(m_a),    32'(exp_a(c)));
            chk({tag, "_cke"},  32'(m_cke),  (c >= 10) ? 32'd1 : 32'd0);
            chk({tag, "_busy"}, 32'(m_busy), (c >= 28) ? 32'd0 : 32'd1);
            chk({tag, "_done"}, 32'(m_done), (c >= 28) ? 32'd1 : 32'd0);
            if (c == 26) begin
                chk({tag, "_bl0_cmd"}, 32'(b0_cmd), 32'h0);
                chk({tag, "_bl0_a"},   32'(b0_a),   32'h037);
                chk({tag, "_bl1_cmd"}, 32'(b1_cmd), 32'h0);
                chk({tag, "_bl1_a"},   32'(b1_a),   32'h020);
            end
            if (c == 28) begin
                chk({tag, "_ba"},      32'(m_ba),    32'd0);
                chk({tag, "_req"},     32'(m_req),   32'd0);
                chk({tag, "_bl0_rdy"}, {28'd0, b0_cke, b0_done, b0_busy, b0_req}, 32'hC);
                chk({tag, "_bl1_rdy"}, {28'd0, b1_cke, b1_done, b1_busy, b1_req}, 32'hC);
                chk({tag, "_bl_ba"},   {28'd0, b0_ba, b1_ba}, 32'd0);
            end
        end
    endtask

    int pre_cnt;
    int ref_cnt;

    initial begin
        // Reset values while reset is held
        rst = 1'b1;
        tick1();
        chk_rst_vals("rst");
        release_rst();
        init_map("init1");

        // First refresh: tick at 128, request at 129
        step_to(128);
        chk("req_before_tick", 32'(m_req), 32'd0);
        step_to(129);
        chk("req_after_tick", 32'(m_req), 32'd1);
        chk("idle_busy", 32'(m_busy), 32'd0);
        step_to(131);
        gnt = 1'b1;
        tick1();
        chk("acc_cmd", 32'(m_cmd), 32'h7);
        chk("acc_busy", 32'(m_busy), 32'd0);
        gnt = 1'b0;
        tick1();
        chk("rf_pre_cmd", 32'(m_cmd), 32'h2);
        chk("rf_pre_a", 32'(m_a), 32'h400);
        chk("rf_pre_busy", 32'(m_busy), 32'd1);
        tick1();
        chk("rf_nop", 32'(m_cmd), 32'h7);
        tick1();
        chk("rf_ref_cmd", 32'(m_cmd), 32'h1);
        chk("rf_ref_busy", 32'(m_busy), 32'd1);
        chk("rf_ref_req", 32'(m_req), 32'd1);
        tick1();
        chk("rf_req_clear", 32'(m_req), 32'd0);
        step_to(141);
        chk("rf_busy_hold", 32'(m_busy), 32'd1);
        tick1();
        chk("rf_busy_drop", 32'(m_busy), 32'd0);
        chk("rf_end_cmd", 32'(m_cmd), 32'h7);

        // Tick at 228 makes one pending; REF placed on the 328 tick
        step_to(229);
        chk("req2", 32'(m_req), 32'd1);
        step_to(324);
        gnt = 1'b1;
        tick1();
        gnt = 1'b0;
        tick1();
        chk("sim_pre", 32'(m_cmd), 32'h2);
        step_to(328);
        chk("sim_ref", 32'(m_cmd), 32'h1);
        tick1();
        chk("sim_req_kept", 32'(m_req), 32'd1);
        step_to(335);
        chk("sim_busy_drop", 32'(m_busy), 32'd0);
        chk("sim_req_still", 32'(m_req), 32'd1);
        gnt = 1'b1;
        tick1();
        gnt = 1'b0;
        step_to(339);
        chk("sim_drain_ref", 32'(m_cmd), 32'h1);
        tick1();
        chk("sim_drain_req", 32'(m_req), 32'd0);

        // Reset from IDLE, then again in the middle of INIT_REF2
        #2 rst = 1'b1;
        #1 chk_rst_vals("rst_idle");
        release_rst();
        step_to(21);
        chk("in_ref2_done", 32'(m_done), 32'd0);
        #2 rst = 1'b1;
        #1 chk_rst_vals("rst_ref2");
        release_rst();
        init_map("init2");

        // Backlog: ticks at 128..828 overflow the 3-bit count at 7
        step_to(849);
        chk("backlog_req", 32'(m_req), 32'd1);
        if ((849 - 28) / 100 > 7)
            $display("[TB] note: %0d ticks before grant, 7 can be held; one refresh is lost by design", (849 - 28) / 100);
        gnt = 1'b1;
        pre_cnt = 0;
        ref_cnt = 0;
        while (cyc < 920) begin
            tick1();
            if (m_cmd == 4'h2) pre_cnt++;
            if (m_cmd == 4'h1) ref_cnt++;
            if (m_cmd != 4'h7) chk("backlog_busy", 32'(m_busy), 32'd1);
        end
        gnt = 1'b0;
        chk("backlog_pre_cnt", 32'(pre_cnt), 32'd7);
        chk("backlog_ref_cnt", 32'(ref_cnt), 32'd7);
        chk("backlog_req_clear", 32'(m_req), 32'd0);

        // Tick at 928 raises a request; reset in RF_PRE right after PRE
        step_to(929);
        chk("post_req", 32'(m_req), 32'd1);
        gnt = 1'b1;
        tick1();
        gnt = 1'b0;
        tick1();
        chk("rfpre_cmd", 32'(m_cmd), 32'h2);
        #2 rst = 1'b1;
        #1 chk_rst_vals("rst_rfpre");
        release_rst();
        init_map("init3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
